// File: rtl/cpu_reset_gen.sv
// rtl/cpu_reset_gen.sv - CPU reset sequencer driven by the asynchronous PLL lock flag
//
// Purpose:
//   Synchronizes the PLL-lock flag, holds the CPU domain in reset until lock
//   has been stable for HOLD_CYCLES, and re-asserts reset if lock is lost for
//   LOSS_FILTER consecutive cycles while running. Clocked by the free-running
//   system clock because the CPU clock is gated until lock.
//
// Ports:
//   sys_clk_i          in   1  free-running system clock
//   reset_i            in   1  synchronous active-high reset
//   ready_async_i      in   1  PLL locked flag, asynchronous to sys_clk_i
//   cpu_reset_o        out  1  registered active-high reset to the CPU domain
//   reset_done_o       out  1  one-cycle pulse on reset release
//   state_o            out  2  0 WAIT_LOCK, 1 HOLD, 2 RUN, 3 FAULT
//   lock_loss_count_o  out  8  saturating RUN->FAULT count (CPU_RESET_LOSS_COUNT_EN only)
//
// Configuration macro: CPU_RESET_LOSS_COUNT_EN enables lock_loss_count_o.

module cpu_reset_gen #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int LOSS_FILTER = 4
) (
  input  logic       sys_clk_i,
  input  logic       reset_i,
  input  logic       ready_async_i,
  output logic       cpu_reset_o,
  output logic       reset_done_o,
  output logic [1:0] state_o
`ifdef CPU_RESET_LOSS_COUNT_EN
  ,
  output logic [7:0] lock_loss_count_o
`endif
);

  localparam int HW = $clog2(HOLD_CYCLES);
  localparam int LW = $clog2(LOSS_FILTER + 1);

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_HOLD      = 2'd1,
    ST_RUN       = 2'd2,
    ST_FAULT     = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [HW-1:0]          hold_cnt_q, hold_cnt_d;
  logic [LW-1:0]          low_cnt_q, low_cnt_d;
  logic                   cpu_reset_q, cpu_reset_d;
  logic                   reset_done_q, reset_done_d;
  logic                   ready_sync;

  // Only the last synchronizer stage is trusted by the FSM.
  assign ready_sync = sync_q[SYNC_STAGES-1];
  assign sync_d     = {sync_q[SYNC_STAGES-2:0], ready_async_i};

  // State, counter and output registers.
  always_ff @(posedge sys_clk_i) begin
    if (reset_i) begin
      state_q      <= ST_WAIT_LOCK;
      sync_q       <= '0;
      hold_cnt_q   <= '0;
      low_cnt_q    <= '0;
      cpu_reset_q  <= 1'b1;
      reset_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      hold_cnt_q   <= hold_cnt_d;
      low_cnt_q    <= low_cnt_d;
      cpu_reset_q  <= cpu_reset_d;
      reset_done_q <= reset_done_d;
    end
  end

  // Next-state logic; both counters are zeroed on every state exit.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    low_cnt_d  = low_cnt_q;
    case (state_q)
      ST_WAIT_LOCK: begin
        if (ready_sync) begin
          state_d    = ST_HOLD;
          hold_cnt_d = '0;
        end
      end
      ST_HOLD: begin
        if (!ready_sync) begin
          state_d    = ST_WAIT_LOCK;
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HW'(HOLD_CYCLES - 1)) begin
          state_d    = ST_RUN;
          hold_cnt_d = '0;
          low_cnt_d  = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      ST_RUN: begin
        if (!ready_sync) begin
          if (low_cnt_q == LW'(LOSS_FILTER - 1)) begin
            state_d   = ST_FAULT;
            low_cnt_d = '0;
          end else begin
            low_cnt_d = low_cnt_q + LW'(1);
          end
        end else begin
          // Short lock glitches are forgiven; any good sample restarts the filter.
          low_cnt_d = '0;
        end
      end
      ST_FAULT: begin
        if (ready_sync) begin
          state_d    = ST_HOLD;
          hold_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ST_WAIT_LOCK;
        hold_cnt_d = '0;
        low_cnt_d  = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they change on the
  // same edge as the transition that causes them.
  always_comb begin
    cpu_reset_d  = (state_d != ST_RUN);
    reset_done_d = (state_q != ST_RUN) && (state_d == ST_RUN);
  end

  assign cpu_reset_o  = cpu_reset_q;
  assign reset_done_o = reset_done_q;
  assign state_o      = state_q;

`ifdef CPU_RESET_LOSS_COUNT_EN
  logic [7:0] loss_cnt_q, loss_cnt_d;

  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if (state_q == ST_RUN && state_d == ST_FAULT && loss_cnt_q != 8'hFF) begin
      loss_cnt_d = loss_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (reset_i) begin
      loss_cnt_q <= 8'd0;
    end else begin
      loss_cnt_q <= loss_cnt_d;
    end
  end

  assign lock_loss_count_o = loss_cnt_q;
`endif

endmodule

// File: tb/tb_cpu_reset_gen.sv
// tb/tb_cpu_reset_gen.sv - table-driven and sequence checks for cpu_reset_gen

module tb_cpu_reset_gen;

  logic       clk;
  logic       reset_i;
  logic       ready_async_i;
  logic       cpu_reset_o;
  logic       reset_done_o;
  logic [1:0] state_o;
`ifdef CPU_RESET_LOSS_COUNT_EN
  logic [7:0] lock_loss_count_o;
`endif

  int total = 0;
  int bad   = 0;

  cpu_reset_gen dut (
    .sys_clk_i     (clk),
    .reset_i       (reset_i),
    .ready_async_i (ready_async_i),
    .cpu_reset_o   (cpu_reset_o),
    .reset_done_o  (reset_done_o),
    .state_o       (state_o)
`ifdef CPU_RESET_LOSS_COUNT_EN
    ,
    .lock_loss_count_o (lock_loss_count_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       rdy;
    logic       exp_cpu;
    logic       exp_done;
    logic [1:0] exp_st;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset_i       = 1'b1;
    ready_async_i = 1'b0;
    repeat (n) tick();
    reset_i = 1'b0;
  endtask

  // Edges until cpu_reset_o reaches the wanted level; 999 on timeout.
  task automatic wait_cpu(input logic lvl, output int n);
    n = 999;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (cpu_reset_o == lvl) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int lat_err;
    int st_err;

    vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd0};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd0};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd0};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd1};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd1};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd1};
    vecs[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd0};
    vecs[9] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd1};

    reset_i       = 1'b1;
    ready_async_i = 1'b0;

    // Reset held, then lock absent for 100 cycles.
    st_err = 0;
    repeat (3) tick();
    reset_i = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (cpu_reset_o !== 1'b1 || state_o !== 2'd0 || reset_done_o !== 1'b0) st_err++;
    end
    check("idle_no_lock", st_err, 0);
    check("idle_cpu_reset", cpu_reset_o, 1);
`ifdef CPU_RESET_LOSS_COUNT_EN
    check("reset_loss_count", lock_loss_count_o, 0);
`endif

    // Cycle-by-cycle vectors: synchronizer latency and a 1-cycle HOLD abort.
    for (int i = 0; i < 10; i++) begin
      reset_i       = vecs[i].rst;
      ready_async_i = vecs[i].rdy;
      tick();
      check($sformatf("vec%0d_cpu", i), cpu_reset_o, vecs[i].exp_cpu);
      check($sformatf("vec%0d_done", i), reset_done_o, vecs[i].exp_done);
      check($sformatf("vec%0d_state", i), state_o, vecs[i].exp_st);
    end

    // Rise-to-release latency and the reset_done pulse.
    do_reset(3);
    ready_async_i = 1'b1;
    wait_cpu(1'b0, n);
    check("rise_latency", n, 19);
    check("release_done", reset_done_o, 1);
    check("release_state", state_o, 2);
    tick();
    check("done_one_cycle", reset_done_o, 0);
    check("run_cpu_reset", cpu_reset_o, 0);

    // HOLD aborted at hold_cnt=8 by a one-cycle drop.
    do_reset(3);
    ready_async_i = 1'b1;
    repeat (11) tick();
    check("hold_at_8", state_o, 1);
    ready_async_i = 1'b0;
    tick();
    ready_async_i = 1'b1;
    tick();
    check("hold_still", state_o, 1);
    tick();
    check("hold_abort", state_o, 0);
    wait_cpu(1'b0, n);
    check("rerise_latency", n + 2, 19);

    // RUN: 3-cycle glitch ignored.
    st_err = 0;
    ready_async_i = 1'b0;
    repeat (3) tick();
    ready_async_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cpu_reset_o !== 1'b0 || state_o !== 2'd2) st_err++;
    end
    check("glitch_ignored", st_err, 0);

    // RUN: sustained loss.
    ready_async_i = 1'b0;
    wait_cpu(1'b1, n);
    check("loss_latency", n, 6);
    check("fault_state", state_o, 3);
`ifdef CPU_RESET_LOSS_COUNT_EN
    check("loss_count_1", lock_loss_count_o, 1);
`endif

    // FAULT -> HOLD -> RUN with a full hold window.
    ready_async_i = 1'b1;
    repeat (2) tick();
    check("fault_wait", state_o, 3);
    tick();
    check("fault_to_hold", state_o, 1);
    wait_cpu(1'b0, n);
    check("fault_recover_latency", n + 3, 19);

    // Repeated faults drive the loss counter into saturation.
    lat_err = 0;
    for (int i = 0; i < 300; i++) begin
      ready_async_i = 1'b0;
      wait_cpu(1'b1, n);
      if (n != 6) lat_err++;
      ready_async_i = 1'b1;
      wait_cpu(1'b0, n);
      if (n != 19) lat_err++;
    end
    check("repeat_fault_latency", lat_err, 0);
`ifdef CPU_RESET_LOSS_COUNT_EN
    check("loss_count_sat", lock_loss_count_o, 8'hFF);
`endif

    // One-cycle reset pulse in RUN with lock held.
    check("pre_pulse_run", state_o, 2);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    check("pulse_cpu_reset", cpu_reset_o, 1);
    check("pulse_state", state_o, 0);
`ifdef CPU_RESET_LOSS_COUNT_EN
    check("pulse_loss_clear", lock_loss_count_o, 0);
`endif
    wait_cpu(1'b0, n);
    check("pulse_release_latency", n, 19);
    check("pulse_release_state", state_o, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
